// File: rtl/dcnn_io_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : dcnn_io_receiver
//  Description : Receiving end of the GPU->accelerator load protocol.
//                Decodes interrupt commands (load CNN / load image / start),
//                requests 16-bit compressed words with a one-cycle 'done'
//                pulse and expands run-length pairs into byte writes to the
//                accelerator memory. Raises a one-cycle 'start' pulse for the
//                DCNN core once both the CNN and image streams are loaded.
//
//  Parameters  : ADDR_W     - memory address width
//                IMG_BASE   - first address of the image region (CNN at 0)
//
//  Ports       : clk        in   clock, rising edge
//                rst        in   asynchronous active-low reset
//                interrupt  in   command strobe
//                load       in   1 = load stream, 0 = start processing
//                cnn        in   1 = CNN weights, 0 = image
//                data       in   [15:0] compressed word from the GPU
//                done       out  one-cycle request for the next word
//                mem_we     out  byte write strobe
//                mem_addr   out  [ADDR_W-1:0] write address
//                mem_wdata  out  [7:0] write byte
//                start      out  one-cycle pulse to the DCNN core
//                cnn_loaded out  sticky: CNN stream complete
//                img_loaded out  sticky: image stream complete
//                busy       out  high whenever not IDLE
//                sum_err    out  sticky: trailer checksum mismatch
//
//  Build option: RX_CHECKSUM_EN - when defined, a trailer word holding the
//                16-bit modulo sum of all expanded bytes is requested after
//                the last byte and compared; otherwise sum_err is tied low.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dcnn_io_receiver #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] IMG_BASE = 'h8000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interrupt,
    input  logic              load,
    input  logic              cnn,
    input  logic [15:0]       data,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              start,
    output logic              cnn_loaded,
    output logic              img_loaded,
    output logic              busy,
    output logic              sum_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HREQ   = 3'd1,
        S_HWAIT  = 3'd2,
        S_REQ    = 3'd3,
        S_WAIT   = 3'd4,
        S_EXPAND = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    state_t            r_state;
    logic              r_target;      // 1 = CNN stream, 0 = image stream
    logic              r_done;
    logic              r_we;
    logic              r_start;
    logic              r_cnn_loaded;
    logic              r_img_loaded;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_byte;
    logic [7:0]        r_run;         // remaining repeats minus one
    logic [15:0]       r_total;       // header byte count T
    logic [15:0]       r_cnt;         // bytes written so far

`ifdef RX_CHECKSUM_EN
    logic              r_trailer;     // HREQ/HWAIT is fetching the trailer
    logic [15:0]       r_sum;
    logic              r_sum_err;
`endif

    logic              w_load_cmd;
    logic              w_start_cmd;
    logic [15:0]       w_cnt_next;
    logic              w_last_byte;
    logic              w_run_end;

    // A load command is honoured in any state (abort + restart); a start
    // command only from IDLE/FINISH and only with both streams present.
    assign w_load_cmd  = interrupt & load;
    assign w_start_cmd = interrupt & ~load & r_cnn_loaded & r_img_loaded;
    assign w_cnt_next  = r_cnt + 16'd1;
    assign w_last_byte = (w_cnt_next == r_total);
    assign w_run_end   = (r_run == 8'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_target     <= 1'b0;
            r_done       <= 1'b0;
            r_we         <= 1'b0;
            r_start      <= 1'b0;
            r_cnn_loaded <= 1'b0;
            r_img_loaded <= 1'b0;
            r_addr       <= '0;
            r_byte       <= 8'd0;
            r_run        <= 8'd0;
            r_total      <= 16'd0;
            r_cnt        <= 16'd0;
`ifdef RX_CHECKSUM_EN
            r_trailer    <= 1'b0;
            r_sum        <= 16'd0;
            r_sum_err    <= 1'b0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_start <= 1'b0;

            if (w_load_cmd) begin
                // New stream: also used as abort when already busy. The
                // flag of an aborted target was cleared when it started.
                r_target <= cnn;
                if (cnn) begin
                    r_cnn_loaded <= 1'b0;
                end else begin
                    r_img_loaded <= 1'b0;
                end
                r_addr  <= cnn ? '0 : IMG_BASE;
                r_cnt   <= 16'd0;
                r_done  <= 1'b1;
                r_state <= S_HREQ;
`ifdef RX_CHECKSUM_EN
                r_trailer <= 1'b0;
                r_sum     <= 16'd0;
                r_sum_err <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_cmd) begin
                            r_start <= 1'b1;
                        end
                    end

                    S_HREQ: begin
                        r_state <= S_HWAIT;
                    end

                    S_HWAIT: begin
`ifdef RX_CHECKSUM_EN
                        if (r_trailer) begin
                            if (data != r_sum) begin
                                r_sum_err <= 1'b1;
                            end
                            if (r_target) begin
                                r_cnn_loaded <= 1'b1;
                            end else begin
                                r_img_loaded <= 1'b1;
                            end
                            r_state <= S_FINISH;
                        end else if (data == 16'd0) begin
                            r_total   <= data;
                            r_trailer <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= S_HREQ;
                        end else begin
                            r_total <= data;
                            r_done  <= 1'b1;
                            r_state <= S_REQ;
                        end
`else
                        r_total <= data;
                        if (data == 16'd0) begin
                            if (r_target) begin
                                r_cnn_loaded <= 1'b1;
                            end else begin
                                r_img_loaded <= 1'b1;
                            end
                            r_state <= S_FINISH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_REQ;
                        end
`endif
                    end

                    S_REQ: begin
                        r_state <= S_WAIT;
                    end

                    S_WAIT: begin
                        r_run   <= data[15:8];
                        r_byte  <= data[7:0];
                        r_we    <= 1'b1;
                        r_state <= S_EXPAND;
                    end

                    S_EXPAND: begin
                        // The write on mem_* happens in this cycle; advance
                        // the pointers for the next one.
                        r_addr <= r_addr + ADDR_W'(1);
                        r_cnt  <= w_cnt_next;
                        r_run  <= r_run - 8'd1;
`ifdef RX_CHECKSUM_EN
                        r_sum  <= r_sum + {8'd0, r_byte};
`endif
                        if (w_last_byte) begin
                            // Also truncates a run that overshoots T.
`ifdef RX_CHECKSUM_EN
                            r_trailer <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= S_HREQ;
`else
                            if (r_target) begin
                                r_cnn_loaded <= 1'b1;
                            end else begin
                                r_img_loaded <= 1'b1;
                            end
                            r_state <= S_FINISH;
`endif
                        end else if (w_run_end) begin
                            r_done  <= 1'b1;
                            r_state <= S_REQ;
                        end else begin
                            r_we <= 1'b1;
                        end
                    end

                    S_FINISH: begin
                        // A command still held high here is taken as if
                        // from IDLE; a one-cycle strobe that hit the last
                        // write is intentionally lost.
                        if (w_start_cmd) begin
                            r_start <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign done       = r_done;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_byte;
    assign start      = r_start;
    assign cnn_loaded = r_cnn_loaded;
    assign img_loaded = r_img_loaded;
    assign busy       = (r_state != S_IDLE);
`ifdef RX_CHECKSUM_EN
    assign sum_err    = r_sum_err;
`else
    assign sum_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/dcnn_io_receiver.md
# dcnn_io_receiver

Receiving end of the GPU→accelerator load protocol. Decodes interrupt commands (load CNN / load image / start processing), requests 16-bit compressed words with a one-cycle `done` pulse, and expands the run-length pairs into byte writes to accelerator memory. When loading is finished it raises a `start` pulse for the DCNN core.

## Interface
- `ADDR_W`, 16: memory address width.
- `IMG_BASE`, 16'h8000: first address of the image region. The CNN region starts at address 0.
- `clk` in 1: single clock. All logic uses the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `interrupt` in 1: command strobe, sampled high for one cycle.
- `load` in 1: with `interrupt`, 1 = load stream, 0 = start processing.
- `cnn` in 1: with `interrupt`/`load`, 1 = CNN weights, 0 = image.
- `data` in 16: compressed word from the GPU.
- `done` out 1: one-cycle request for the next word.
- `mem_we` out 1: byte write strobe.
- `mem_addr` out ADDR_W: write address.
- `mem_wdata` out 8: write byte.
- `start` out 1: one-cycle pulse to the DCNN core.
- `cnn_loaded` out 1: sticky flag, CNN stream complete.
- `img_loaded` out 1: sticky flag, image stream complete.
- `busy` out 1: high in every state except IDLE.
- `sum_err` out 1: sticky flag, checksum mismatch.

## Operation
- Stream format:
  - Word 0 is the header: the total expanded byte count `T` (0..65535).
  - Each following word is a pair: `data[15:8]` = run length minus 1 (giving 1..256 repeats), `data[7:0]` = byte value.
- States: IDLE, HREQ, HWAIT, REQ, WAIT, EXPAND, FINISH.
- IDLE:
  - `interrupt & load`: latch `cnn` as the target. Clear the target's loaded flag and `sum_err`. Set the address to 0 (CNN) or `IMG_BASE` (image). Go to HREQ.
  - `interrupt & ~load`: pulse `start` on the next cycle, but only if `cnn_loaded & img_loaded`. Otherwise ignore.
- HREQ: drive `done`=1, go to HWAIT. HWAIT: capture `data` as `T`. If `T`=0 go to FINISH, else go to REQ.
- REQ: drive `done`=1, go to WAIT. WAIT: capture run/byte, go to EXPAND.
- EXPAND:
  - One write per cycle with `mem_we`=1. The address increments after each write. The written-byte counter increments.
  - When the run is exhausted, or the written count reaches `T`: go to FINISH if count==`T`, else go to REQ.
  - A run longer than the remaining count is truncated silently.
- FINISH: set `cnn_loaded` or `img_loaded` for the latched target, go to IDLE.
- Address arithmetic wraps modulo 2^ADDR_W. The byte counter is 16 bits and never exceeds `T`.
- `interrupt` outside IDLE with `load`=1 aborts the transfer and restarts at HREQ for the new target. The flag of the aborted target stays cleared.
- `interrupt` outside IDLE with `load`=0 is ignored.

## Timing
- Reset values: `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `start`=0, `cnn_loaded`=0, `img_loaded`=0, `busy`=0, `sum_err`=0, state IDLE.
- Handshake:
  - `done` is high for exactly one cycle N.
  - The GPU updates `data` at the falling edge inside cycle N.
  - `data` is sampled at the rising edge that ends cycle N+1.
  - `done` is never asserted on two consecutive cycles.
- Latencies:
  - Interrupt sampled → first `done`: 1 cycle.
  - Pair word captured → first `mem_we`: 1 cycle.
  - Per pair: 2 request cycles + R write cycles.
- Last write → loaded flag set: 1 cycle.
- Start interrupt sampled → `start` pulse: 1 cycle.
- A simultaneous `interrupt` and final write: the write completes, then the new command is taken from FINISH→IDLE only if `interrupt` is still high. Otherwise the command is lost, which is by design (the GPU holds `interrupt` one cycle).

## Configuration
- `RX_CHECKSUM_EN` defined:
  - After the last byte, the block issues one extra HREQ/HWAIT-style request for a trailer word. The trailer is the 16-bit modulo sum of all expanded bytes.
  - On mismatch, `sum_err` is set. The loaded flag is still set.
- `RX_CHECKSUM_EN` undefined: no trailer request, `sum_err` is tied to 0.

## Test plan
- Reset mid-EXPAND (`rst` low for 3 cycles) → all outputs return to their reset values immediately. A following CNN load works normally.
- CNN load with header 4, pair 16'h03AB → writes AB to addresses 0..3, exactly 2 `done` pulses, then `cnn_loaded`=1.
- Image load with header 5, pairs 16'h0111 and 16'h0422 → writes 11,11 then 22,22,22 at 8000..8004; the second run is truncated; then `img_loaded`=1.
- Header 0 → no `mem_we`, `img_loaded`=1 one cycle after HWAIT.
- Start interrupt with only `cnn_loaded` → no `start`. After both flags are set, the start interrupt → `start` high for 1 cycle.
- With `RX_CHECKSUM_EN`, header 2, pair 16'h0105, trailer 16'h000B → `sum_err`=1. With trailer 16'h000A → `sum_err`=0.
